// File: rtl/systolic_pkg.sv
// systolic_pkg: shared array geometry, drain FSM encoding and saturation bounds
package systolic_pkg;
  localparam int ARRAY_SIZE = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ACC_WIDTH = 2*DATA_WIDTH+5;
  localparam int IDX_WIDTH = 6;
  localparam int DIAG_WIDTH = $clog2(ARRAY_SIZE);
  localparam int SAT_CNT_WIDTH = 11;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    HOLD   = 2'd2,
    DONE   = 2'd3
  } drain_state_t;
  // DATA_WIDTH signed limits, sign-extended to accumulator width for comparison
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
endpackage

// File: rtl/systolic_drain_requant_lane.sv
// requant_lane: arithmetic shift, optional ReLU and saturation of one accumulator lane
module requant_lane
  import systolic_pkg::*;
(
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic [5:0]            shift_amt,
  input  logic                  relu_en,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  sat
);
  logic signed [ACC_WIDTH-1:0] s;
  logic signed [ACC_WIDTH-1:0] r;
  logic hi;
  logic lo;
  always_comb begin
    s = $signed(acc) >>> shift_amt;
    r = (relu_en && s[ACC_WIDTH-1]) ? '0 : s;
    hi = r > ACC_MAX;
    lo = r < ACC_MIN;
    sat = hi | lo;
    q = hi ? ACC_MAX[DATA_WIDTH-1:0] : lo ? ACC_MIN[DATA_WIDTH-1:0] : r[DATA_WIDTH-1:0];
  end
endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: walks the array diagonals, requantizes each lane set and
// streams one beat per valid/ready handshake to the output writer.
module systolic_drain
  import systolic_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             drain_start,
  input  logic [5:0]                       shift_amt,
  input  logic                             relu_en,
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  mul_outcome,
  output logic [IDX_WIDTH-1:0]             matrix_index,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_data,
  output logic [DIAG_WIDTH-1:0]            out_diag,
  output logic                             busy,
  output logic                             drain_done,
  output logic [SAT_CNT_WIDTH-1:0]         sat_count
);
  drain_state_t state;
  drain_state_t state_nx;
  logic [DIAG_WIDTH-1:0] cnt;
  logic [5:0] shift_q;
  logic relu_q;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] q_all;
  logic [ARRAY_SIZE-1:0] sat_vec;
  logic [DIAG_WIDTH:0] sat_beat;
  logic accept;
  logic last;

  genvar g;
  generate
    for (g = 0; g < ARRAY_SIZE; g++) begin : g_lane
      requant_lane u_lane (
        .acc       (mul_outcome[g*ACC_WIDTH +: ACC_WIDTH]),
        .shift_amt (shift_q),
        .relu_en   (relu_q),
        .q         (q_all[g*DATA_WIDTH +: DATA_WIDTH]),
        .sat       (sat_vec[g])
      );
    end
  endgenerate

  always_comb begin
    sat_beat = '0;
    for (int i = 0; i < ARRAY_SIZE; i++)
      sat_beat = sat_beat + (DIAG_WIDTH+1)'(sat_vec[i]);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = drain_start ? SAMPLE : IDLE;
      SAMPLE:  state_nx = HOLD;
      HOLD:    state_nx = accept ? (last ? DONE : SAMPLE) : HOLD;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    out_valid = state == HOLD;
    drain_done = state == DONE;
    busy = state != IDLE;
    matrix_index = (state == IDLE) ? '0 : IDX_WIDTH'(cnt);
    accept = out_valid && out_ready;
    last = cnt == DIAG_WIDTH'(ARRAY_SIZE-1);
  end

  // Shift/ReLU settings are frozen at start so mid-drain changes cannot split a matrix
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      shift_q <= '0;
      relu_q <= 1'b0;
      out_data <= '0;
      out_diag <= '0;
      sat_count <= '0;
    end else begin
      if (state == IDLE && drain_start) begin
        shift_q <= shift_amt;
        relu_q <= relu_en;
        sat_count <= '0;
        cnt <= '0;
      end
      if (state == SAMPLE) begin
        out_data <= q_all;
        out_diag <= cnt;
        sat_count <= sat_count + SAT_CNT_WIDTH'(sat_beat);
      end
      if (accept && !last) cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: directed drains against a behavioural array model with hand-set lane values
module tb_systolic_drain;
  import systolic_pkg::*;
  localparam int AW = ARRAY_SIZE*ACC_WIDTH;
  localparam int DW = ARRAY_SIZE*DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] P40 = 69'sd1099511627776;
  localparam logic signed [ACC_WIDTH-1:0] P45 = 69'sd35184372088832;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drain_start = 1'b0;
  logic [5:0] shift_amt = '0;
  logic relu_en = 1'b0;
  logic out_ready = 1'b0;
  logic [AW-1:0] mul_outcome;
  logic [IDX_WIDTH-1:0] matrix_index;
  logic out_valid;
  logic [DW-1:0] out_data;
  logic [DIAG_WIDTH-1:0] out_diag;
  logic busy;
  logic drain_done;
  logic [SAT_CNT_WIDTH-1:0] sat_count;

  int vectors = 0;
  int miscompares = 0;
  int mode = 0;
  logic signed [ACC_WIDTH-1:0] lane_val [ARRAY_SIZE];
  logic [DATA_WIDTH-1:0] exp_lane [ARRAY_SIZE];
  int beats;
  bit done_seen;

  always #5 clk = ~clk;

  systolic_drain dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .drain_start  (drain_start),
    .shift_amt    (shift_amt),
    .relu_en      (relu_en),
    .mul_outcome  (mul_outcome),
    .matrix_index (matrix_index),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_diag     (out_diag),
    .busy         (busy),
    .drain_done   (drain_done),
    .sat_count    (sat_count)
  );

  // Array model: mode 0 gives C[i][j]=i*32+j on diagonals, mode 1 gives fixed lane values
  always_comb begin
    mul_outcome = '0;
    for (int i = 0; i < ARRAY_SIZE; i++)
      mul_outcome[i*ACC_WIDTH +: ACC_WIDTH] = (mode == 0) ?
        ACC_WIDTH'(i*32 + ((int'(matrix_index) - i) & 31)) : lane_val[i];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [5:0] sh, input logic re);
    shift_amt = sh;
    relu_en = re;
    drain_start = 1'b1;
    @(posedge clk); #1;
    drain_start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_novalid", 64'(out_valid), 64'd0);
  endtask

  task automatic run(input int rmode, input int poke_at, input int abort_at, input bit b2b,
                     output int nb, output bit dn);
    int cyc;
    int last_acc;
    int stall;
    int first_v;
    bit acc_prev;
    logic [DATA_WIDTH-1:0] e;
    cyc = 0; nb = 0; dn = 0; last_acc = -10; stall = 0; first_v = -1; acc_prev = 0;
    while (!dn && cyc < 1000) begin
      out_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : (rmode == 2) ? !(nb == 3 && stall < 10) : 1'b1;
      drain_start = (poke_at >= 0 && nb == poke_at) || (b2b && nb == ARRAY_SIZE);
      if (poke_at >= 0 && nb == poke_at) shift_amt = 6'd5;
      @(negedge clk);
      if (acc_prev) check("valid_drop", 64'(out_valid), 64'd0);
      if (abort_at >= 0 && nb == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_midx", 64'(matrix_index), 64'd0);
        check("abort_done", 64'(drain_done), 64'd0);
        break;
      end
      acc_prev = out_valid && out_ready;
      if (out_valid && first_v < 0) first_v = cyc;
      if (drain_done) begin
        dn = 1;
        check("done_lat", 64'(cyc - last_acc), 64'd1);
        if (b2b) check("busy_at_done", 64'(busy), 64'd1);
      end else if (out_valid) begin
        check("diag", 64'(out_diag), 64'(nb));
        check("midx", 64'(matrix_index), 64'(nb));
        if (out_ready) begin
          for (int i = 0; i < ARRAY_SIZE; i++) begin
            e = (mode == 0) ? DATA_WIDTH'(i*32 + ((nb - i) & 31)) : exp_lane[i];
            check("lane", 64'(out_data[i*DATA_WIDTH +: DATA_WIDTH]), 64'(e));
          end
          nb++;
          last_acc = cyc;
        end else if (nb == 3) stall++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (abort_at < 0) check("first_valid_lat", 64'(first_v), 64'd1);
    if (rmode == 2) check("stall_cycles", 64'(stall), 64'd10);
    drain_start = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic set_lanes(input logic signed [ACC_WIDTH-1:0] v, input logic [DATA_WIDTH-1:0] e);
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      lane_val[i] = v;
      exp_lane[i] = e;
    end
  endtask

  initial begin
    set_lanes('0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(drain_done), 64'd0);
    check("rst_midx", 64'(matrix_index), 64'd0);
    check("rst_sat", 64'(sat_count), 64'd0);
    check("rst_diag", 64'(out_diag), 64'd0);
    check("rst_data", out_data[63:0], 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // plain drain, C[i][j]=i*32+j
    mode = 0;
    start(6'd0, 1'b0);
    run(0, -1, -1, 0, beats, done_seen);
    check("beats_plain", 64'(beats), 64'd32);
    check("done_plain", 64'(done_seen), 64'd1);
    check("sat_plain", 64'(sat_count), 64'd0);
    check("idle_after", 64'(busy), 64'd0);

    // -1000 >>> 3 = -125
    mode = 1;
    set_lanes('0, '0);
    lane_val[0] = -69'sd1000; exp_lane[0] = 32'hFFFFFF83;
    start(6'd3, 1'b0);
    run(0, -1, -1, 0, beats, done_seen);
    check("beats_shift3", 64'(beats), 64'd32);
    check("sat_shift3", 64'(sat_count), 64'd0);

    // 2^40>>>4 and -2^40>>>4 saturate; -1000>>>4 = -63
    set_lanes('0, '0);
    lane_val[0] = P40;  exp_lane[0] = 32'h7FFFFFFF;
    lane_val[1] = -P40; exp_lane[1] = 32'h80000000;
    lane_val[2] = -69'sd1000; exp_lane[2] = 32'hFFFFFFC1;
    start(6'd4, 1'b0);
    run(0, -1, -1, 0, beats, done_seen);
    check("beats_sat", 64'(beats), 64'd32);
    check("sat_two_per_beat", 64'(sat_count), 64'd64);

    // -2^40 unshifted, then a start during DONE and one right after
    set_lanes('0, '0);
    lane_val[0] = -P40; exp_lane[0] = 32'h80000000;
    start(6'd0, 1'b0);
    run(0, -1, -1, 1, beats, done_seen);
    check("beats_min", 64'(beats), 64'd32);
    check("b2b_ignored", 64'(busy), 64'd0);
    check("sat_min", 64'(sat_count), 64'd32);
    mode = 0;
    start(6'd0, 1'b0);
    check("sat_cleared", 64'(sat_count), 64'd0);
    run(2, -1, -1, 0, beats, done_seen);
    check("beats_backpressure", 64'(beats), 64'd32);
    check("sat_backpressure", 64'(sat_count), 64'd0);

    // ReLU clamps -5 and -2^45 to 0 without saturation; positives pass through
    mode = 1;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      lane_val[i] = (i % 2 == 1) ? -P45 : -69'sd5;
      exp_lane[i] = '0;
    end
    lane_val[31] = 69'sd77; exp_lane[31] = 32'd77;
    start(6'd0, 1'b1);
    run(0, -1, -1, 0, beats, done_seen);
    check("beats_relu", 64'(beats), 64'd32);
    check("sat_relu", 64'(sat_count), 64'd0);

    // random ready
    mode = 0;
    start(6'd0, 1'b0);
    run(1, -1, -1, 0, beats, done_seen);
    check("beats_random", 64'(beats), 64'd32);
    check("done_random", 64'(done_seen), 64'd1);

    // restart attempt + shift change at beat 10, reset at beat 20
    start(6'd0, 1'b0);
    run(0, 10, 20, 0, beats, done_seen);
    check("beats_abort", 64'(beats), 64'd20);
    check("done_abort", 64'(done_seen), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("no_done_in_rst", 64'(drain_done), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_done_after_rst", 64'(drain_done), 64'd0);
    end
    @(posedge clk); #1;
    start(6'd0, 1'b0);
    run(0, -1, -1, 0, beats, done_seen);
    check("beats_fresh", 64'(beats), 64'd32);
    check("done_fresh", 64'(done_seen), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
